// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths and
// the owner encoding used to steer the BRAM port.
package dmem_pkg;

  localparam int unsigned WIDTH_B_DEF = 32;
  localparam int unsigned ADDR_B_DEF  = 10;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_starve_timer.sv
// Saturating count of cycles a pending debug request has been blocked;
// expired flags that the next debug access must be forced through.
module dmem_starve_timer #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic blocked,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (blocked && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data BRAM between the MEM stage (fixed priority)
// and the debug unit, with a starvation timer forcing one debug access.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH_B    = WIDTH_B_DEF,
  parameter int unsigned ADDR_B     = ADDR_B_DEF,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_mem_read,
  input  logic               cpu_mem_write,
  input  logic [ADDR_B-1:0]  cpu_addr,
  input  logic [WIDTH_B-1:0] cpu_wdata,
  output logic [WIDTH_B-1:0] cpu_rdata,
  output logic               cpu_stall,
  input  logic               dbg_req,
  input  logic               dbg_we,
  input  logic [ADDR_B-1:0]  dbg_addr,
  input  logic [WIDTH_B-1:0] dbg_wdata,
  output logic               dbg_gnt,
  output logic               dbg_rvalid,
  output logic [WIDTH_B-1:0] dbg_rdata,
  output logic               ram_we,
  output logic [ADDR_B-1:0]  ram_addr,
  output logic [WIDTH_B-1:0] ram_din,
  input  logic [WIDTH_B-1:0] ram_dout
);

  logic   cpu_active;
  logic   cpu_wr;
  logic   expired;
  logic   force_dbg;
  owner_e owner;
  logic   rd_owner_dbg_q;
  logic   rd_owner_dbg_d;

  assign cpu_active = cpu_mem_read | cpu_mem_write;
  // Simultaneous read and write requests are treated as a read.
  assign cpu_wr     = cpu_mem_write & ~cpu_mem_read;
  assign force_dbg  = expired & dbg_req;

  always_comb begin
    owner     = OWNER_CPU;
    ram_addr  = cpu_addr;
    ram_din   = cpu_wdata;
    ram_we    = cpu_wr & ~reset;
    dbg_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (force_dbg || (dbg_req && !cpu_active)) begin
      owner = OWNER_DBG;
    end
    if (owner == OWNER_DBG) begin
      ram_addr  = dbg_addr;
      ram_din   = dbg_wdata;
      ram_we    = dbg_we & ~reset;
      dbg_gnt   = ~reset;
      cpu_stall = force_dbg & cpu_active & ~reset;
    end
  end

  dmem_starve_timer #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_timer (
    .clk    (clk),
    .reset  (reset),
    .blocked(dbg_req & cpu_active & ~dbg_gnt),
    .clear  (~dbg_req | dbg_gnt),
    .expired(expired)
  );

  assign rd_owner_dbg_d = dbg_gnt & ~dbg_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_dbg_q <= 1'b0;
    end else begin
      rd_owner_dbg_q <= rd_owner_dbg_d;
    end
  end

  assign dbg_rvalid = rd_owner_dbg_q & ~reset;
  assign dbg_rdata  = ram_dout;
  assign cpu_rdata  = ram_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_dmem_port_arbiter;

  localparam int SMAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_read, cpu_mem_write;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_gnt, dbg_rvalid;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  int total = 0;
  int bad   = 0;

  logic [31:0] bram    [0:1023];
  logic [31:0] exp_mem [0:1023];

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .WIDTH_B(32),
    .ADDR_B(10),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port BRAM with one-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_we) bram[ram_addr] <= ram_din;
    ram_dout <= bram[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    cpu_mem_write = 1; cpu_addr = 10'h005; cpu_wdata = 32'hAAAA5555;
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h006;
    tick();
    @(negedge clk);
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%0b want=0", ram_we); end
    total++; if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL reset_dbg_gnt got=%0b want=0", dbg_gnt); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_cpu_stall got=%0b want=0", cpu_stall); end
    total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL reset_dbg_rvalid got=%0b want=0", dbg_rvalid); end
    tick();
    reset = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_cpu_rw();
    cpu_mem_write = 1; cpu_addr = 10'h010; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (ram_we !== 1'b1 || ram_addr !== 10'h010 || ram_din !== 32'hDEADBEEF) begin
      bad++; $display("FAIL cpu_write we=%0b addr=%h din=%h want 1/010/deadbeef", ram_we, ram_addr, ram_din); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_write_stall got=%0b want=0", cpu_stall); end
    exp_mem[10'h010] = 32'hDEADBEEF;
    tick();
    cpu_mem_write = 0; cpu_mem_read = 1;
    @(negedge clk);
    total++; if (ram_we !== 1'b0 || cpu_stall !== 1'b0) begin
      bad++; $display("FAIL cpu_read we=%0b stall=%0b want 0/0", ram_we, cpu_stall); end
    tick();
    cpu_mem_write = 1; cpu_mem_read = 1; cpu_addr = 10'h020; cpu_wdata = 32'h0BADF00D;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL cpu_rdata got=%h want=deadbeef", cpu_rdata); end
    total++; if (ram_we !== 1'b0 || ram_addr !== 10'h020) begin
      bad++; $display("FAIL cpu_rd_wr_both we=%0b addr=%h want 0/020", ram_we, ram_addr); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_dbg_rw();
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h3FF; dbg_wdata = 32'h12345678;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h3FF || ram_din !== 32'h12345678) begin
      bad++; $display("FAIL dbg_write gnt=%0b we=%0b addr=%h din=%h want 1/1/3ff/12345678",
                      dbg_gnt, ram_we, ram_addr, ram_din); end
    exp_mem[10'h3FF] = 32'h12345678;
    tick();
    dbg_we = 0;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1 || ram_we !== 1'b0 || dbg_rvalid !== 1'b0) begin
      bad++; $display("FAIL dbg_read gnt=%0b we=%0b rvalid=%0b want 1/0/0", dbg_gnt, ram_we, dbg_rvalid); end
    tick();
    dbg_req = 0;
    @(negedge clk);
    total++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h12345678) begin
      bad++; $display("FAIL dbg_rdata rvalid=%0b data=%h want 1/12345678", dbg_rvalid, dbg_rdata); end
    tick();
    @(negedge clk);
    total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL dbg_rvalid_once got=%0b want=0", dbg_rvalid); end
    tick();
  endtask

  task automatic test_starve();
    cpu_mem_read = 1; cpu_addr = 10'h010;
    dbg_req = 1; dbg_we = 0; dbg_addr = 10'h3FF;
    for (int c = 0; c <= 2 * SMAX + 1; c++) begin
      logic want = (c == SMAX) || (c == 2 * SMAX + 1);
      @(negedge clk);
      total++; if (dbg_gnt !== want || cpu_stall !== want) begin
        bad++; $display("FAIL starve_c%0d gnt=%0b stall=%0b want %0b", c, dbg_gnt, cpu_stall, want); end
      if (c == SMAX) begin
        total++; if (ram_addr !== 10'h3FF) begin bad++; $display("FAIL starve_addr got=%h want=3ff", ram_addr); end
      end
      if (c == SMAX + 1) begin
        total++; if (ram_addr !== 10'h010 || dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h12345678) begin
          bad++; $display("FAIL starve_after addr=%h rvalid=%0b data=%h want 010/1/12345678",
                          ram_addr, dbg_rvalid, dbg_rdata); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_abandon();
    cpu_mem_read = 1; cpu_addr = 10'h011;
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h012; dbg_wdata = 32'hFFFF0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (dbg_gnt !== 1'b0 || ram_we !== 1'b0) begin
        bad++; $display("FAIL abandon_c%0d gnt=%0b we=%0b want 0/0", c, dbg_gnt, ram_we); end
      tick();
    end
    dbg_req = 0;
    tick();
    dbg_req = 1; dbg_we = 0;
    for (int c = 0; c <= SMAX; c++) begin
      logic want = (c == SMAX);
      @(negedge clk);
      total++; if (dbg_gnt !== want) begin
        bad++; $display("FAIL abandon_retry_c%0d gnt=%0b want=%0b", c, dbg_gnt, want); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_after_read();
    dbg_req = 1; dbg_we = 0; dbg_addr = 10'h010;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL rst_rd_gnt got=%0b want=1", dbg_gnt); end
    tick();
    reset = 1;
    cpu_mem_write = 1; cpu_addr = 10'h001; dbg_we = 1;
    tick();
    @(negedge clk);
    total++; if (dbg_rvalid !== 1'b0 || ram_we !== 1'b0 || cpu_stall !== 1'b0 || dbg_gnt !== 1'b0) begin
      bad++; $display("FAIL rst_after_read rvalid=%0b we=%0b stall=%0b gnt=%0b want 0/0/0/0",
                      dbg_rvalid, ram_we, cpu_stall, dbg_gnt); end
    tick();
    reset = 0;
    idle_inputs();
    @(negedge clk);
    total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rst_release_rvalid got=%0b want=0", dbg_rvalid); end
    tick();
  endtask

  // Reference: a debug request that has waited SMAX CPU-busy cycles wins;
  // otherwise the CPU wins whenever it is active.
  task automatic test_random();
    int          waited = 0;
    logic        last_gnt = 0;
    logic        p_dbg = 0, p_cpu = 0;
    logic [31:0] p_dbg_data = '0, p_cpu_data = '0;
    for (int n = 0; n < 3000; n++) begin
      int          mode = $urandom_range(0, 9);
      logic        act, own_dbg, e_we;
      logic [9:0]  e_addr;
      logic [31:0] e_din;
      cpu_mem_read  = (mode >= 3 && mode <= 6) || mode == 9;
      cpu_mem_write = mode >= 7;
      cpu_addr  = 10'($urandom_range(0, 63));
      cpu_wdata = $urandom;
      if (!dbg_req || last_gnt) begin
        if ((!dbg_req && $urandom_range(0, 2) == 0) || (dbg_req && $urandom_range(0, 1) == 0)) begin
          dbg_req = 1; dbg_we = $urandom_range(0, 1) == 1;
          dbg_addr = 10'($urandom_range(0, 63)); dbg_wdata = $urandom;
        end else begin
          dbg_req = 0;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        dbg_req = 0;
      end
      act     = cpu_mem_read || cpu_mem_write;
      own_dbg = dbg_req && (!act || waited == SMAX);
      e_we    = own_dbg ? dbg_we : (cpu_mem_write && !cpu_mem_read);
      e_addr  = own_dbg ? dbg_addr : cpu_addr;
      e_din   = own_dbg ? dbg_wdata : cpu_wdata;
      @(negedge clk);
      total++; if (dbg_gnt !== own_dbg || cpu_stall !== (own_dbg && act)) begin
        bad++; $display("FAIL rnd%0d_arb gnt=%0b stall=%0b want %0b/%0b", n, dbg_gnt, cpu_stall, own_dbg, own_dbg && act); end
      total++; if (ram_we !== e_we || ram_addr !== e_addr || (e_we && ram_din !== e_din)) begin
        bad++; $display("FAIL rnd%0d_ram we=%0b addr=%h din=%h want %0b/%h/%h", n, ram_we, ram_addr, ram_din, e_we, e_addr, e_din); end
      total++; if (dbg_rvalid !== p_dbg || (p_dbg && dbg_rdata !== p_dbg_data)) begin
        bad++; $display("FAIL rnd%0d_dbg_rd rvalid=%0b data=%h want %0b/%h", n, dbg_rvalid, dbg_rdata, p_dbg, p_dbg_data); end
      if (p_cpu) begin
        total++; if (cpu_rdata !== p_cpu_data) begin
          bad++; $display("FAIL rnd%0d_cpu_rd got=%h want=%h", n, cpu_rdata, p_cpu_data); end
      end
      p_dbg = own_dbg && !dbg_we;
      p_dbg_data = exp_mem[dbg_addr];
      p_cpu = !own_dbg && cpu_mem_read;
      p_cpu_data = exp_mem[cpu_addr];
      if (e_we) exp_mem[e_addr] = e_din;
      if (!dbg_req || own_dbg) waited = 0;
      else if (act && waited < SMAX) waited++;
      last_gnt = own_dbg;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bram[i] = '0;
      exp_mem[i] = '0;
    end
    idle_inputs();
    reset = 1;
    #1;
    test_reset();
    test_cpu_rw();
    test_dbg_rw();
    test_starve();
    test_abandon();
    test_reset_after_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
